// File: rtl/obc_da_pkg.sv
// Shared FSM encoding, ROM table type and default DFT coefficient table for the OBC DA accumulator.
// Latency: none (types, constants and elaboration-time helper functions only).
// Backpressure: none.
package obc_da_pkg;

    localparam int OBC_NGRP_MAX = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } obc_state_e;

    typedef logic signed [31:0] obc_word_t;
    // Word 2*g+a is group g's entry for address a (a = odd bit ^ even bit).
    typedef obc_word_t [0:2*OBC_NGRP_MAX-1] obc_rom_t;

    // Real part of the 16-point DFT twiddles for bin 1, Q16.
    function automatic int dft_cos_q16(input int n);
        case (n & 15)
            0:       return 65536;
            1, 15:   return 60547;
            2, 14:   return 46341;
            3, 13:   return 25080;
            4, 12:   return 0;
            5, 11:   return -25080;
            6, 10:   return -46341;
            7, 9:    return -60547;
            default: return -65536;
        endcase
    endfunction

    // Entries are -(c_even + c_odd)/2 and -(c_even - c_odd)/2, so that with the
    // matching offset the accumulator yields sum(c * x) directly.
    function automatic obc_rom_t obc_dft_rom();
        obc_rom_t rom;
        int       ce;
        int       co;
        for (int g = 0; g < OBC_NGRP_MAX; g++) begin
            ce           = dft_cos_q16(2 * g);
            co           = dft_cos_q16(2 * g + 1);
            rom[2*g]     = obc_word_t'(-(ce + co) / 2);
            rom[2*g+1]   = obc_word_t'(-(ce - co) / 2);
        end
        return rom;
    endfunction

    // The OBC expansion leaves a residue of -sum(address-0 words); this cancels it.
    function automatic longint obc_offset(input obc_rom_t rom, input int ngrp);
        longint s;
        s = 0;
        for (int g = 0; g < ngrp; g++) s += longint'($signed(rom[2*g]));
        return s;
    endfunction

    localparam obc_rom_t OBC_DEFAULT_ROM = obc_dft_rom();
    localparam longint   OBC_OFFSET      = obc_offset(OBC_DEFAULT_ROM, OBC_NGRP_MAX);

endpackage

// File: rtl/obc_grp_lut.sv
// Per-group two-entry partial-product ROM with conditional two's-complement negation.
// Latency: combinational.
// Backpressure: none.
module obc_grp_lut
    import obc_da_pkg::*;
#(
    parameter int        COEF_W = 32,
    parameter obc_word_t W0     = '0,
    parameter obc_word_t W1     = '0
) (
    input  logic                     addr,
    input  logic                     sign,
    output logic signed [COEF_W-1:0] word
);

    localparam logic signed [COEF_W-1:0] W0_C = COEF_W'(W0);
    localparam logic signed [COEF_W-1:0] W1_C = COEF_W'(W1);

    logic signed [COEF_W-1:0] sel;

    assign sel  = addr ? W1_C : W0_C;
    assign word = sign ? -sel : sel;

endmodule

// File: rtl/obc_da_acc.sv
// Bit-serial offset-binary DA accumulator, MSB first; OBC_ACC_SAT_EN clamps instead of wrapping.
// Latency: B+1 cycles from in_valid&&in_ready to out_valid; one vector in flight at a time.
// Backpressure: result held in HOLD until out_ready; in_ready only in IDLE.
module obc_da_acc
    import obc_da_pkg::*;
#(
    parameter int       NGRP   = 8,
    parameter int       B      = 8,
    parameter int       COEF_W = 32,
    parameter int       OUT_W  = 32,
    parameter obc_rom_t ROM    = OBC_DEFAULT_ROM,
    parameter longint   OFFSET = OBC_OFFSET
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2*NGRP*B-1:0]     x_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] y_out,
    output logic                    busy
);

    localparam int            ACC_W = COEF_W + B + $clog2(NGRP);
    localparam int            KW    = (B > 1) ? $clog2(B) : 1;
    localparam logic [KW-1:0] K_MSB = KW'(B - 1);

    obc_state_e               state;
    logic [2*NGRP*B-1:0]      x_sh;
    logic [KW-1:0]            k;
    logic                     fin;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  p_sum;
    logic signed [ACC_W-1:0]  fin_val;
    logic signed [OUT_W-1:0]  y_nxt;
    logic [NGRP-1:0]          bit_e;
    logic [NGRP-1:0]          bit_o;
    logic signed [COEF_W-1:0] term [NGRP];
    logic                     is_msb;

    assign is_msb    = (k == K_MSB);
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_HOLD);
    assign busy      = (state != ST_IDLE);

    // The whole vector shifts left; each channel's top bit is the current slice
    // for B shifts, since bits crossing in from the channel below stay beneath it.
    for (genvar g = 0; g < NGRP; g++) begin : g_grp
        assign bit_e[g] = x_sh[(2*g)*B + B-1];
        assign bit_o[g] = x_sh[(2*g+1)*B + B-1];

        obc_grp_lut #(
            .COEF_W (COEF_W),
            .W0     (ROM[2*g]),
            .W1     (ROM[2*g+1])
        ) u_lut (
            .addr (bit_e[g] ^ bit_o[g]),
            .sign (is_msb ^ bit_e[g]),
            .word (term[g])
        );
    end

    always_comb begin
        p_sum = '0;
        for (int g = 0; g < NGRP; g++) p_sum = p_sum + ACC_W'(term[g]);
    end

    assign fin_val = acc + ACC_W'(OFFSET);

`ifdef OBC_ACC_SAT_EN
    localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'({1'b0, {(OUT_W-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

    always_comb begin
        y_nxt = OUT_W'(fin_val);
        if (fin_val > Y_MAX)      y_nxt = {1'b0, {(OUT_W-1){1'b1}}};
        else if (fin_val < Y_MIN) y_nxt = {1'b1, {(OUT_W-1){1'b0}}};
    end
`else
    assign y_nxt = OUT_W'(fin_val);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            x_sh  <= '0;
            k     <= K_MSB;
            fin   <= 1'b0;
            acc   <= '0;
            y_out <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state <= ST_RUN;
                        x_sh  <= x_in;
                        acc   <= '0;
                        k     <= K_MSB;
                        fin   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // After slice 0 one extra cycle applies the offset and output range.
                    if (fin) begin
                        y_out <= y_nxt;
                        fin   <= 1'b0;
                        state <= ST_HOLD;
                    end else begin
                        acc  <= (acc <<< 1) + p_sum;
                        x_sh <= x_sh << 1;
                        if (k == '0) fin <= 1'b1;
                        else         k   <= k - KW'(1);
                    end
                end
                ST_HOLD: begin
                    if (out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_obc_da_acc.sv
// Three DUT configurations (DFT table, all-ones table, 16-bit 0x7FFF table) driven in lockstep;
// expected results come from the direct inner product the OBC table encodes.
module tb_obc_da_acc;
    import obc_da_pkg::*;

    localparam int       XW   = 128;
    localparam obc_rom_t ROM0 = OBC_DEFAULT_ROM;
    localparam obc_rom_t ROM1 = {16{32'sd1}};
    localparam obc_rom_t ROM2 = {16{32'sh0000_7fff}};

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          out_ready;
    logic [XW-1:0] x_in;
    logic          in_ready0, in_ready1, in_ready2;
    logic          out_valid0, out_valid1, out_valid2;
    logic          busy0, busy1, busy2;
    logic [31:0]   y0, y1;
    logic [15:0]   y2;

    bit            manual_rdy = 1'b1;
    int            n_chk = 0;
    int            n_err = 0;
    logic [31:0]   q0[$];
    logic [31:0]   q1[$];
    logic [15:0]   q2[$];

    always #5 clk = ~clk;

    obc_da_acc u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .x_in(x_in),
        .out_valid(out_valid0), .out_ready(out_ready), .y_out(y0), .busy(busy0)
    );

    obc_da_acc #(.ROM(ROM1), .OFFSET(obc_offset(ROM1, 8))) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .x_in(x_in),
        .out_valid(out_valid1), .out_ready(out_ready), .y_out(y1), .busy(busy1)
    );

    obc_da_acc #(.OUT_W(16), .ROM(ROM2), .OFFSET(obc_offset(ROM2, 8))) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .x_in(x_in),
        .out_valid(out_valid2), .out_ready(out_ready), .y_out(y2), .busy(busy2)
    );

    // Table (A,B) per group realises coefficients c_even = -(A+B), c_odd = -(A-B).
    function automatic longint ip(input obc_rom_t rom, input logic [XW-1:0] x);
        longint y, a, b, xe, xo;
        y = 0;
        for (int g = 0; g < 8; g++) begin
            a  = longint'($signed(rom[2*g]));
            b  = longint'($signed(rom[2*g+1]));
            xe = longint'($signed(x[16*g +: 8]));
            xo = longint'($signed(x[16*g+8 +: 8]));
            y  = y - (a + b) * xe - (a - b) * xo;
        end
        return y;
    endfunction

    function automatic logic [31:0] fit32(input longint v);
`ifdef OBC_ACC_SAT_EN
        if (v > 64'sd2147483647)  return 32'h7fff_ffff;
        if (v < -64'sd2147483648) return 32'h8000_0000;
`endif
        return v[31:0];
    endfunction

    function automatic logic [15:0] fit16(input longint v);
`ifdef OBC_ACC_SAT_EN
        if (v > 64'sd32767)  return 16'h7fff;
        if (v < -64'sd32768) return 16'h8000;
`endif
        return v[15:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [XW-1:0] rand_vec();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Called aligned to posedge+1; returns aligned to posedge+1 after the accept edge.
    task automatic send(input logic [XW-1:0] x, input bit keep);
        int t;
        t = 0;
        while (!in_ready0 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("in_ready_wait", in_ready0, 1'b1);
        in_valid = 1'b1;
        x_in     = x;
        @(posedge clk); #1;
        in_valid = 1'b0;
        x_in     = rand_vec();
        if (keep) begin
            q0.push_back(fit32(ip(ROM0, x)));
            q1.push_back(fit32(ip(ROM1, x)));
            q2.push_back(fit16(ip(ROM2, x)));
        end
    endtask

    initial forever begin
        @(posedge clk); #1;
        if (!manual_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: compare every presented result against the head of its queue.
    initial forever begin
        @(negedge clk);
        if (out_valid0) begin
            if (q0.size() == 0) chk("spurious_vld0", out_valid0, 1'b0);
            else begin
                chk("y0", y0, q0[0]);
                if (out_ready) void'(q0.pop_front());
            end
        end
        if (out_valid1) begin
            if (q1.size() == 0) chk("spurious_vld1", out_valid1, 1'b0);
            else begin
                chk("y1", y1, q1[0]);
                if (out_ready) void'(q1.pop_front());
            end
        end
        if (out_valid2) begin
            if (q2.size() == 0) chk("spurious_vld2", out_valid2, 1'b0);
            else begin
                chk("y2", y2, q2[0]);
                if (out_ready) void'(q2.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int cnt;
        rst       = 1'b1;
        in_valid  = 1'b0;
        x_in      = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", in_ready0, 1'b1);
        chk("rst_out_valid", out_valid0, 1'b0);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_y0", y0, 32'h0);
        chk("rst_y2", y2, 16'h0);
        chk("rst_out_valid2", out_valid2, 1'b0);

        // Single all-zero vector on the all-ones table: latency and value.
        send('0, 1'b1);
        chk("run_busy", busy1, 1'b1);
        chk("run_in_ready", in_ready1, 1'b0);
        cnt = 0;
        while (!out_valid1 && cnt < 50) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("latency", cnt, 9);

        // Backpressure: hold the result for 20 cycles, then accept.
        send(rand_vec(), 1'b1);
        out_ready = 1'b0;
        cnt = 0;
        while (!out_valid0 && cnt < 50) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("bp_valid", out_valid0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("bp_in_ready", in_ready0, 1'b0);
            chk("bp_hold", out_valid0, 1'b1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_accept", out_valid0, 1'b0);
        chk("bp_idle", in_ready0, 1'b1);

        // Reset during RUN: no result, then a clean vector.
        send(rand_vec(), 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_in_ready", in_ready0, 1'b1);
        chk("mid_rst_busy", busy0, 1'b0);
        chk("mid_rst_y0", y0, 32'h0);
        repeat (15) begin
            @(posedge clk); #1;
        end
        chk("mid_rst_no_vld", out_valid0, 1'b0);
        send(rand_vec(), 1'b1);

        // Range extremes on the 16-bit instance.
        send({16{8'h80}}, 1'b1);
        send({8{8'h00, 8'h7f}}, 1'b1);
        send({16{8'h7f}}, 1'b1);

        manual_rdy = 1'b0;
        for (int i = 0; i < 1000; i++) send(rand_vec(), 1'b1);

        cnt = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && cnt < 300) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("drain", q0.size() + q1.size() + q2.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
